// File: rtl/arb_bus_if.sv
// Signal bundle between the sources/sink and arb_bus.
// The lock vector exists only when ARB_BUS_LOCK_EN is defined.
interface arb_bus_if #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 6,
  parameter int SELW  = $clog2(NSRC)
);
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] data;
`ifdef ARB_BUS_LOCK_EN
  logic [NSRC-1:0]       lock;
`endif
  logic                  out_ready;
  logic [NSRC-1:0]       gnt;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic [SELW-1:0]       out_src;

`ifdef ARB_BUS_LOCK_EN
  modport master (output req, data, lock, out_ready,
                  input  gnt, out, out_valid, out_src);
  modport slave  (input  req, data, lock, out_ready,
                  output gnt, out, out_valid, out_src);
`else
  modport master (output req, data, out_ready,
                  input  gnt, out, out_valid, out_src);
  modport slave  (input  req, data, out_ready,
                  output gnt, out, out_valid, out_src);
`endif
endinterface

// File: rtl/arb_bus.sv
// Round-robin arbiter plus registered output bus with a valid/ready handshake.
// Defining ARB_BUS_LOCK_EN enables lock-based burst ownership by the last winner.
module arb_bus #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 6,
  parameter int SELW  = $clog2(NSRC)
) (
  input logic      clk,
  input logic      rst,
  arb_bus_if.slave bus
);

  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [SELW-1:0]  r_src;
  logic [SELW-1:0]  r_ptr;
  logic [SELW-1:0]  r_last;

  logic             w_accept;
  logic             w_found;
  logic             w_locked;
  logic             w_fire;
  logic [SELW-1:0]  w_winner;
  logic [SELW-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_data;
  logic [NSRC-1:0]  w_lock;
  int               w_start;
  int               w_idx;

`ifdef ARB_BUS_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = '0;
`endif

  assign w_accept = !r_valid || bus.out_ready;

  // An out-of-range pointer restarts the scan at source 0.
  always_comb begin
    w_found  = 1'b0;
    w_locked = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_start  = (int'(r_ptr) < NSRC) ? int'(r_ptr) : 0;
    if (int'(r_last) < NSRC && w_lock[r_last] && bus.req[r_last]) begin
      w_found  = 1'b1;
      w_locked = 1'b1;
      w_winner = r_last;
    end
    for (int k = 0; k < NSRC; k++) begin
      w_idx = w_start + k;
      if (w_idx >= NSRC) w_idx = w_idx - NSRC;
      if (!w_found && bus.req[w_idx[SELW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_winner == SELW'(i)) w_data = bus.data[i*WIDTH +: WIDTH];
    end
  end

  assign w_fire    = w_accept && w_found && !rst;
  assign w_ptr_nxt = (int'(w_winner) == NSRC - 1) ? '0 : w_winner + 1'b1;

  always_comb begin
    bus.gnt = '0;
    if (w_fire) bus.gnt = NSRC'(1) << w_winner;
  end

  // A locked repeat win keeps the pointer so round-robin resumes where it left off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_last  <= '0;
    end else if (w_accept) begin
      if (w_found) begin
        r_out   <= w_data;
        r_valid <= 1'b1;
        r_src   <= w_winner;
        r_last  <= w_winner;
        if (!w_locked) r_ptr <= w_ptr_nxt;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.out_src   = r_src;

endmodule
